// File: rtl/boot_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : boot_pkg                                                   |
// | Purpose : Shared types and constants for the UART instruction-memory |
// |           boot loader.                                               |
// | Contents: boot_state_t  - loader state encoding                      |
// |           BOOT_NOP      - instruction fed to the CPU while held      |
// |           LEN_BYTES     - number of length-prefix bytes              |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package boot_pkg;

   typedef enum logic [2:0] {
      ST_RUN  = 3'd0,
      ST_LEN0 = 3'd1,
      ST_LEN1 = 3'd2,
      ST_DATA = 3'd3,
      ST_CSUM = 3'd4,
      ST_ERR  = 3'd5
   } boot_state_t;

   localparam logic [31:0] BOOT_NOP  = 32'h0000_0000;
   localparam int          LEN_BYTES = 2;

endpackage
`default_nettype wire

// File: rtl/word_assembler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : word_assembler                                             |
// | Purpose : Packs a stream of bytes into little-endian 32-bit words.   |
// | Ports   : clk, reset      - clock, synchronous active-high reset     |
// |           clear_i         - synchronous restart of byte position     |
// |           byte_valid_i    - byte strobe                              |
// |           byte_i[7:0]     - incoming byte                            |
// |           word_valid_o    - high with the 4th byte of a word         |
// |           word_o[31:0]    - assembled word (valid with word_valid_o) |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module word_assembler (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear_i,
   input  logic        byte_valid_i,
   input  logic [7:0]  byte_i,
   output logic        word_valid_o,
   output logic [31:0] word_o
);

   logic [1:0]  cnt_q;
   logic [31:0] shift_q;

   // Bytes enter at the top and move down, so after four bytes the first
   // one received sits in bits 7:0.
   always_ff @(posedge clk) begin
      if (reset || clear_i) begin
         cnt_q   <= 2'd0;
         shift_q <= 32'h0000_0000;
      end else if (byte_valid_i) begin
         cnt_q   <= cnt_q + 2'd1;
         shift_q <= {byte_i, shift_q[31:8]};
      end
   end

   // The word is presented combinationally with its 4th byte so the caller
   // can register it in the same cycle as the strobe.
   assign word_valid_o = byte_valid_i && (cnt_q == 2'd3);
   assign word_o       = {byte_i, shift_q[31:8]};

endmodule
`default_nettype wire

// File: rtl/imem_boot_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : imem_boot_loader                                           |
// | Purpose : Owns the instruction-memory port. In boot mode it holds    |
// |           the CPU and writes a length-prefixed, XOR-checksummed      |
// |           image received over UART; otherwise it passes CPU fetches  |
// |           straight through to the memory.                            |
// | Ports   : clk, reset         - clock, synchronous active-high reset  |
// |           uart_on            - boot request level (rise = start)     |
// |           rx_valid, rx_data  - UART byte strobe and byte             |
// |           cpu_pc, cpu_instr  - CPU fetch address / returned instr    |
// |           mem_addr, mem_we,                                          |
// |           mem_wdata, mem_rdata - instruction-memory port             |
// |           cpu_hold           - CPU held in reset while high          |
// |           load_ok            - one-cycle pulse on accepted image     |
// |           load_err           - high while in the error state         |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module imem_boot_loader
   import boot_pkg::*;
#(
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  uart_on,
   input  logic                  rx_valid,
   input  logic [7:0]            rx_data,
   input  logic [31:0]           cpu_pc,
   output logic [31:0]           cpu_instr,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_we,
   output logic [31:0]           mem_wdata,
   input  logic [31:0]           mem_rdata,
   output logic                  cpu_hold,
   output logic                  load_ok,
   output logic                  load_err
);

   localparam logic [ADDR_WIDTH-1:0] IDX_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

   boot_state_t           state_q, state_d;
   logic                  uart_q;
   logic [15:0]           len_q, len_d;
   logic [7:0]            csum_q, csum_d;
   logic [ADDR_WIDTH-1:0] idx_q, idx_d;
   logic                  we_q, we_d;
   logic [31:0]           wdata_q, wdata_d;
   logic                  ok_q, ok_d;

   logic                  w_rise;
   logic                  w_start;
   logic                  w_byte_valid;
   logic                  w_word_valid;
   logic [31:0]           w_word;
   logic [15:0]           w_len_new;
   logic                  w_len_too_big;
   logic                  w_last_word;
   logic                  w_unused_pc;

   assign w_rise  = uart_on && !uart_q;
   // A rise is only acted on from the idle or error state; in the load
   // states uart_on is already high, so a rise there cannot occur.
   assign w_start = w_rise && ((state_q == ST_RUN) || (state_q == ST_ERR));

   // Aborting (uart_on low) takes priority over a data byte so a partial
   // word never reaches memory.
   assign w_byte_valid  = (state_q == ST_DATA) && uart_on && rx_valid;
   assign w_len_new     = {rx_data, len_q[7:0]};
   assign w_len_too_big = ({16'h0000, w_len_new} > (32'd1 << ADDR_WIDTH));
   // The previous word's index bump always lands before the next 4th byte
   // can arrive, so idx_q is the index of the word being completed.
   assign w_last_word   = (32'(idx_q) == (32'(len_q) - 32'd1));

   word_assembler u_word_assembler (
      .clk          (clk),
      .reset        (reset),
      .clear_i      (w_start),
      .byte_valid_i (w_byte_valid),
      .byte_i       (rx_data),
      .word_valid_o (w_word_valid),
      .word_o       (w_word)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_RUN;
         uart_q  <= 1'b0;
         len_q   <= 16'h0000;
         csum_q  <= 8'h00;
         idx_q   <= '0;
         we_q    <= 1'b0;
         wdata_q <= 32'h0000_0000;
         ok_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         uart_q  <= uart_on;
         len_q   <= len_d;
         csum_q  <= csum_d;
         idx_q   <= idx_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
         ok_q    <= ok_d;
      end
   end

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      csum_d  = csum_q;
      // The write index advances at the end of the write cycle itself.
      idx_d   = we_q ? (idx_q + IDX_ONE) : idx_q;
      we_d    = 1'b0;
      wdata_d = wdata_q;
      ok_d    = 1'b0;

      case (state_q)
         ST_RUN: ;
         ST_LEN0: begin
            if (!uart_on) begin
               state_d = ST_ERR;
            end else if (rx_valid) begin
               len_d[7:0] = rx_data;
               csum_d     = csum_q ^ rx_data;
               state_d    = ST_LEN1;
            end
         end
         ST_LEN1: begin
            if (!uart_on) begin
               state_d = ST_ERR;
            end else if (rx_valid) begin
               len_d  = w_len_new;
               csum_d = csum_q ^ rx_data;
               if (w_len_too_big) begin
                  state_d = ST_ERR;
               end else if (w_len_new == 16'h0000) begin
                  state_d = ST_CSUM;
               end else begin
                  state_d = ST_DATA;
               end
            end
         end
         ST_DATA: begin
            if (!uart_on) begin
               state_d = ST_ERR;
            end else if (rx_valid) begin
               csum_d = csum_q ^ rx_data;
               if (w_word_valid) begin
                  we_d    = 1'b1;
                  wdata_d = w_word;
                  // Move on now so a back-to-back checksum byte is
                  // consumed in CSUM while the last write completes.
                  if (w_last_word) begin
                     state_d = ST_CSUM;
                  end
               end
            end
         end
         ST_CSUM: begin
            if (!uart_on) begin
               state_d = ST_ERR;
            end else if (rx_valid) begin
               if (rx_data == csum_q) begin
                  state_d = ST_RUN;
                  ok_d    = 1'b1;
               end else begin
                  state_d = ST_ERR;
               end
            end
         end
         ST_ERR: ;
         default: state_d = ST_ERR;
      endcase

      if (w_start) begin
         state_d = ST_LEN0;
         len_d   = 16'h0000;
         csum_d  = 8'h00;
         idx_d   = '0;
      end
   end

   assign cpu_hold  = (state_q != ST_RUN);
   assign cpu_instr = (state_q == ST_RUN) ? mem_rdata : BOOT_NOP;
   assign mem_addr  = (state_q == ST_RUN) ? cpu_pc[ADDR_WIDTH+1:2] : idx_q;
   assign mem_we    = we_q;
   assign mem_wdata = wdata_q;
   assign load_ok   = ok_q;
   assign load_err  = (state_q == ST_ERR);

   // Byte-offset and out-of-range PC bits do not select a memory word.
   assign w_unused_pc = ^{cpu_pc[31:ADDR_WIDTH+2], cpu_pc[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_imem_boot_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_imem_boot_loader                                        |
// | Purpose : Self-checking bench for imem_boot_loader. Expected memory  |
// |           writes, load_ok and load_err events come from an image-    |
// |           level model and are matched by an independent monitor.     |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_imem_boot_loader;

   localparam int AW    = 8;
   localparam int DEPTH = 1 << AW;

   localparam int EV_WR  = 0;
   localparam int EV_OK  = 1;
   localparam int EV_ERR = 2;

   typedef struct packed {
      logic [1:0]    kind;
      logic [AW-1:0] addr;
      logic [31:0]   data;
   } ev_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          uart_on;
   logic          rx_valid;
   logic [7:0]    rx_data;
   logic [31:0]   cpu_pc;
   logic [31:0]   cpu_instr;
   logic [AW-1:0] mem_addr;
   logic          mem_we;
   logic [31:0]   mem_wdata;
   logic [31:0]   mem_rdata;
   logic          cpu_hold;
   logic          load_ok;
   logic          load_err;

   int   total = 0;
   int   bad   = 0;
   ev_t  exp_q[$];
   logic [7:0]  cur_bytes[$];
   logic [31:0] mem     [0:DEPTH-1];
   logic [31:0] exp_mem [0:DEPTH-1];
   logic        fill;
   logic        err_prev = 1'b0;
   int          last_words;

   always #5 clk = ~clk;

   imem_boot_loader #(.ADDR_WIDTH(AW)) dut (
      .clk       (clk),
      .reset     (reset),
      .uart_on   (uart_on),
      .rx_valid  (rx_valid),
      .rx_data   (rx_data),
      .cpu_pc    (cpu_pc),
      .cpu_instr (cpu_instr),
      .mem_addr  (mem_addr),
      .mem_we    (mem_we),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .cpu_hold  (cpu_hold),
      .load_ok   (load_ok),
      .load_err  (load_err)
   );

   function automatic logic [31:0] init_word(input int i);
      return (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
   endfunction

   // Instruction memory: combinational read, synchronous write.
   always @(posedge clk) begin
      if (fill) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= init_word(i);
      end else if (mem_we) begin
         mem[mem_addr] <= mem_wdata;
      end
   end
   assign mem_rdata = mem[mem_addr];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic expect_event(input int kind, input logic [AW-1:0] a, input logic [31:0] d);
      ev_t e;
      total++;
      if (exp_q.size() == 0) begin
         bad++;
         $display("FAIL unexpected_event: got kind=%0d addr=%h data=%h expected none", kind, a, d);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != 2'(kind) || e.addr != a || e.data != d) begin
            bad++;
            $display("FAIL event: got kind=%0d addr=%h data=%h expected kind=%0d addr=%h data=%h",
                     kind, a, d, e.kind, e.addr, e.data);
         end
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents an event.
   always @(negedge clk) begin
      if (!reset) begin
         if (mem_we) expect_event(EV_WR, mem_addr, mem_wdata);
         if (load_ok) begin
            expect_event(EV_OK, '0, 32'h0);
            check("hold_with_ok", {31'h0, cpu_hold}, 32'h0);
         end
         if (load_err && !err_prev) expect_event(EV_ERR, '0, 32'h0);
      end
      err_prev = load_err;
   end

   task automatic push_ev(input int kind, input int a, input logic [31:0] d);
      ev_t e;
      e.kind = 2'(kind);
      e.addr = AW'(a);
      e.data = d;
      exp_q.push_back(e);
   endtask

   // Image-level reference: interprets the first nsent bytes of cur_bytes
   // as length, data words and checksum. outcome: 0 none, 1 ok, 2 error.
   task automatic model(input int nsent, input bit aborted, output int outcome);
      int          len;
      logic [7:0]  x;
      logic [31:0] w;
      bit          done;
      x = 8'h00; len = 0; done = 1'b0; outcome = 0; last_words = 0;
      for (int i = 0; i < nsent && !done; i++) begin
         if (i < 2) begin
            x ^= cur_bytes[i];
            if (i == 1) begin
               len = int'(cur_bytes[0]) + 256 * int'(cur_bytes[1]);
               if (len > DEPTH) begin
                  push_ev(EV_ERR, 0, 32'h0); outcome = 2; done = 1'b1;
               end
            end
         end else if (i < 2 + 4 * len) begin
            x ^= cur_bytes[i];
            if ((i - 2) % 4 == 3) begin
               w = {cur_bytes[i], cur_bytes[i-1], cur_bytes[i-2], cur_bytes[i-3]};
               push_ev(EV_WR, (i - 2) / 4, w);
               exp_mem[(i - 2) / 4] = w;
               last_words = (i - 2) / 4 + 1;
            end
         end else begin
            if (cur_bytes[i] == x) begin
               push_ev(EV_OK, 0, 32'h0); outcome = 1;
            end else begin
               push_ev(EV_ERR, 0, 32'h0); outcome = 2;
            end
            done = 1'b1;
         end
      end
      if (!done && aborted) begin
         push_ev(EV_ERR, 0, 32'h0); outcome = 2;
      end
   endtask

   task automatic build_image(input int len, input bit corrupt);
      logic [7:0] x;
      logic [7:0] b;
      cur_bytes.delete();
      cur_bytes.push_back(8'(len));
      cur_bytes.push_back(8'(len >> 8));
      x = 8'(len) ^ 8'(len >> 8);
      for (int i = 0; i < 4 * len; i++) begin
         b = 8'($urandom);
         cur_bytes.push_back(b);
         x ^= b;
      end
      cur_bytes.push_back(corrupt ? (x ^ 8'h01) : x);
   endtask

   // Drives bytes; gapmode 0 is fully back-to-back, 1 adds random idles.
   task automatic send_seq(input int nsent, input int gapmode);
      for (int i = 0; i < nsent; i++) begin
         if (gapmode != 0) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         rx_valid = 1'b1;
         rx_data  = cur_bytes[i];
         @(posedge clk); #1;
         rx_valid = 1'b0;
         rx_data  = 8'($urandom);
         if (i == 0) begin
            check("hold_in_load", {31'h0, cpu_hold}, 32'h1);
            check("nop_in_load", cpu_instr, 32'h0);
         end
      end
   endtask

   task automatic run_image(input bit toggle, input int gapmode, input int drop_after);
      int nsent;
      int outcome;
      int a;
      if (toggle) begin
         uart_on = 1'b0;
         repeat (2) begin @(posedge clk); #1; end
         uart_on = 1'b1;
      end
      @(posedge clk); #1;
      nsent = (drop_after >= 0) ? drop_after : cur_bytes.size();
      model(nsent, drop_after >= 0, outcome);
      send_seq(nsent, gapmode);
      if (drop_after >= 0) uart_on = 1'b0;
      if (outcome == 1) begin
         check("ok_pulse", {31'h0, load_ok}, 32'h1);
         check("hold_fall", {31'h0, cpu_hold}, 32'h0);
         @(posedge clk); #1;
         check("ok_one_cycle", {31'h0, load_ok}, 32'h0);
      end else if (outcome == 2 && drop_after < 0) begin
         check("err_next_cycle", {31'h0, load_err}, 32'h1);
      end
      repeat (4) begin @(posedge clk); #1; end
      check("queue_drained", 32'(exp_q.size()), 32'h0);
      if (outcome == 1) begin
         check("err_low_run", {31'h0, load_err}, 32'h0);
         for (int i = 0; i < last_words && i < 4; i++) begin
            a = (i == 3) ? last_words - 1 : i;
            cpu_pc = $urandom;
            cpu_pc[AW+1:2] = AW'(a);
            #1;
            check("fetch_addr", 32'(mem_addr), 32'(a));
            check("fetch_instr", cpu_instr, exp_mem[a]);
         end
      end else if (outcome == 2) begin
         check("err_level", {31'h0, load_err}, 32'h1);
         check("err_hold", {31'h0, cpu_hold}, 32'h1);
         check("err_nop", cpu_instr, 32'h0);
      end
   endtask

   initial begin
      int o;
      fill = 1'b1; reset = 1'b1; uart_on = 1'b0; rx_valid = 1'b0;
      rx_data = 8'h00; cpu_pc = 32'h10;
      for (int i = 0; i < DEPTH; i++) exp_mem[i] = init_word(i);
      @(posedge clk); #1;
      fill = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      check("rst_we", {31'h0, mem_we}, 32'h0);
      check("rst_wdata", mem_wdata, 32'h0);
      reset = 1'b0;
      #1;
      check("rst_addr", 32'(mem_addr), 32'h4);
      check("rst_instr", cpu_instr, exp_mem[4]);
      check("rst_hold", {31'h0, cpu_hold}, 32'h0);
      check("rst_ok", {31'h0, load_ok}, 32'h0);
      check("rst_err", {31'h0, load_err}, 32'h0);
      repeat (3) begin @(posedge clk); #1; end

      for (int gm = 0; gm < 2; gm++) begin
         cur_bytes = {8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                      8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h28};
         run_image(1'b1, gm, -1);
         cur_bytes = {8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                      8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h29};
         run_image(1'b1, gm, -1);
         build_image(3, 1'b0);
         run_image(1'b1, gm, -1);
         cur_bytes = {8'h00, 8'h00, 8'h00};
         run_image(1'b1, gm, -1);
         cur_bytes = {8'h01, 8'h01};
         run_image(1'b1, gm, -1);
         cur_bytes = {8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                      8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h28};
         run_image(1'b1, gm, 4);
      end

      for (int k = 0; k < 8; k++) begin
         build_image($urandom_range(0, 5), ($urandom_range(0, 3) == 0));
         if ($urandom_range(0, 3) == 0)
            run_image(1'b1, $urandom_range(0, 1), $urandom_range(1, cur_bytes.size() - 1));
         else
            run_image(1'b1, $urandom_range(0, 1), -1);
      end

      // Reset in the middle of a load keeps the written word and, with
      // uart_on still high, re-enters the loader on its own.
      build_image(2, 1'b0);
      uart_on = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      uart_on = 1'b1;
      @(posedge clk); #1;
      model(6, 1'b0, o);
      send_seq(6, 0);
      repeat (3) begin @(posedge clk); #1; end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("rst_mid_hold", {31'h0, cpu_hold}, 32'h0);
      check("rst_mid_drained", 32'(exp_q.size()), 32'h0);
      build_image(2, 1'b0);
      run_image(1'b0, 0, -1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/imem_boot_loader.md
# imem_boot_loader

Boot-time controller that owns the instruction-memory port inside the bus. While `uart_on` is high it holds the CPU, receives a length-prefixed, checksummed program image byte by byte from the UART receiver, and writes it word by word into instruction memory. Otherwise it passes CPU fetch addresses and instructions straight through. It lets the team replace `$readmemh` preloading with in-system loading over UART.

## Interface
- ADDR_WIDTH, 8, instruction-memory word-address width; depth = 2^ADDR_WIDTH words
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- uart_on  in  1  boot-mode request level; a rising edge starts a load
- rx_valid  in  1  one-cycle strobe; `rx_data` is valid in that cycle
- rx_data  in  8  received UART byte
- cpu_pc  in  32  CPU fetch byte address
- cpu_instr  out  32  instruction returned to the CPU
- mem_addr  out  ADDR_WIDTH  instruction-memory word address
- mem_we  out  1  instruction-memory write enable
- mem_wdata  out  32  instruction-memory write data
- mem_rdata  in  32  instruction-memory read data (combinational read)
- cpu_hold  out  1  holds the CPU in reset while high
- load_ok  out  1  one-cycle pulse when an image is accepted
- load_err  out  1  level; high while in state ERR

## Operation
- States: RUN, LEN0, LEN1, DATA, CSUM, ERR.
- Rising-edge detect on `uart_on` uses register `uart_q`; `uart_q` resets to 0.
  - If `uart_on` is high through reset, the first cycle after reset sees a rise.
- RUN:
  - `cpu_hold`=0; `mem_addr`=`cpu_pc[ADDR_WIDTH+1:2]`; `cpu_instr`=`mem_rdata`.
  - `rx_valid` is ignored.
  - `uart_on` rise -> LEN0; clear the byte counter, word index and checksum.
- All other states:
  - `cpu_hold`=1; `cpu_instr`=32'h0000_0000 (nop).
  - `mem_addr` = loader word index.
- LEN0: on `rx_valid`, `len[7:0]`=byte -> LEN1.
- LEN1: on `rx_valid`, `len[15:8]`=byte, then:
  - len > 2^ADDR_WIDTH -> ERR;
  - len == 0 -> CSUM;
  - otherwise -> DATA.
- DATA: bytes are assembled little-endian (first byte = bits 7:0).
  - On the 4th byte, write the assembled word at the current word index and increment the index.
  - After word len-1 is written -> CSUM.
- CSUM:
  - Running checksum = XOR of every byte from LEN0 through the last data byte.
  - Received byte == checksum -> RUN with a `load_ok` pulse.
  - Received byte != checksum -> ERR.
- ERR:
  - `cpu_hold`=1, `load_err`=1, no writes.
  - Exit only by a `uart_on` rise (-> LEN0) or by reset.
- `uart_on` low in LEN0/LEN1/DATA/CSUM -> ERR next cycle.
  - An incomplete partial word is never written.
- `uart_on` rise and the abort condition cannot coincide; a rise while in ERR restarts the load.

## Timing
- Reset values: state RUN, `cpu_hold`=0, `mem_we`=0, `mem_wdata`=0, `load_ok`=0, `load_err`=0, all counters and checksum 0.
- RUN fetch path is combinational: `cpu_pc` -> `mem_addr`, `mem_rdata` -> `cpu_instr`, zero added latency.
- Write path is registered: `mem_we` is high for exactly one cycle, the cycle after the 4th byte's `rx_valid`.
  - `mem_addr`/`mem_wdata` are stable in that cycle.
  - The index increments at the end of that cycle.
- `rx_valid` may assert on consecutive cycles; every strobe is consumed and none is dropped.
- `load_ok` is asserted in the first RUN cycle after CSUM; `cpu_hold` falls in that same cycle.
- Reset mid-load: RUN next cycle and loaded words are kept; a still-high `uart_on` then re-enters LEN0.

## Structure
- Package `boot_pkg`:
  - state enum `boot_state_t`;
  - `BOOT_NOP` = 32'h0;
  - `LEN_BYTES` = 2.
- Sub-module `word_assembler`:
  - 2-bit byte counter, 32-bit shift register;
  - outputs `word_valid` and `word`;
  - synchronous `clear` input.
- The FSM, checksum, index counter and port mux stay in the top.

## Test plan
- Reset with `uart_on`=0, `cpu_pc`=32'h10 -> `mem_addr`=4, `cpu_instr`=`mem_rdata`, `cpu_hold`=0, `mem_we` never high.
- `uart_on` rise, then bytes 02 00 78 56 34 12 EF BE AD DE 28 -> two writes, in order:
  - 32'h12345678 @0;
  - 32'hDEADBEEF @1.
  - Then one-cycle `load_ok`, `cpu_hold` falls the same cycle, and the fetch path is restored.
- Same image with checksum byte 29 -> ERR, `load_err`=1, `cpu_hold` stays 1. A later `uart_on` low->high plus a valid image recovers.
- Bytes 00 00 00 -> zero writes, `load_ok` pulse.
- Bytes 01 01 (len 257, ADDR_WIDTH=8) -> ERR in the cycle after the 2nd byte, no writes.
- `uart_on` drops after the first 2 data bytes -> ERR, no write of the partial word. The bench also checks back-to-back `rx_valid` for every scenario.
